cic_interpolator: RTL and testbench

3-stage CIC interpolation filter, the transmit-side counterpart of the team's 3-stage CIC decimator: rate R = 32, differential delay M = 2, identical 26-bit two's-complement internal arithmetic. It accepts one signed 8-bit low-rate sample every 32 `cic_clk` cycles through a valid/ready handshake. It produces one filtered high-rate sample per `cic_clk` cycle, for the upconversion path ahead of the DAC.

---
 rtl/cic_interpolator.sv | 119 +++++++++++
 tb/tb_cic_interpolator.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_interpolator.sv
// cic_interpolator: 3-stage CIC interpolator, R=32, M=2, 26-bit modular arithmetic.
// Optional macro CIC_INTERP_UNDERFLOW_HOLD_EN: a missed slot repeats the last accepted
// sample instead of feeding zero into the comb section.
module cic_interpolator #(
  parameter int DIN_W     = 8,
  parameter int ACC_W     = 26,
  parameter int RATE_LOG2 = 5
) (
  input  logic                    cic_clk,
  input  logic                    cic_rstn,
  input  logic signed [DIN_W-1:0] cic_din,
  input  logic                    cic_din_valid,
  output logic                    cic_din_ready,
  output logic signed [ACC_W-1:0] cic_dout,
  output logic                    cic_dout_valid,
  output logic                    cic_underflow
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [RATE_LOG2-1:0] cnt_q, cnt_d;
  logic accept, miss, slot, first;
  logic signed [DIN_W-1:0] fill, smp;
  logic signed [ACC_W-1:0] x, c1, c2, c3, int_in;
  logic signed [ACC_W-1:0] x1_q, x2_q, c11_q, c12_q, c21_q, c22_q, comb_q;
  logic signed [ACC_W-1:0] i1_q, i2_q, i3_q;
  logic stuff_q, uf_q, vld_q;
  logic [2:0] first_q;
  // State register and phase counter
  always_ff @(posedge cic_clk or negedge cic_rstn) begin
    if (!cic_rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // Next state: IDLE leaves on the first valid sample, RUN is left only by reset
  always_comb begin
    state_d = (state_q == IDLE && cic_din_valid) ? RUN : state_q;
    cnt_d   = (state_q == IDLE) ? (cic_din_valid ? RATE_LOG2'(1) : '0) : cnt_q + RATE_LOG2'(1);
  end
  // Outputs of the FSM: ready always in IDLE, once per period in RUN
  always_comb begin
    cic_din_ready = (state_q == IDLE) || (cnt_q == '0);
    accept        = cic_din_valid && cic_din_ready;
    miss          = (state_q == RUN) && (cnt_q == '0) && !cic_din_valid;
    first         = (state_q == IDLE) && cic_din_valid;
  end
  assign slot = accept || miss;
`ifdef CIC_INTERP_UNDERFLOW_HOLD_EN
  logic signed [DIN_W-1:0] last_din_q;
  // Remember the most recent accepted sample to repeat it on a missed slot
  always_ff @(posedge cic_clk or negedge cic_rstn) begin
    if (!cic_rstn) last_din_q <= '0;
    else if (accept) last_din_q <= cic_din;
  end
  assign fill = last_din_q;
`else
  assign fill = '0;
`endif
  assign smp    = accept ? cic_din : fill;
  assign x      = {{(ACC_W-DIN_W){smp[DIN_W-1]}}, smp};
  assign c1     = x - x2_q;
  assign c2     = c1 - c12_q;
  assign c3     = c2 - c22_q;
  assign int_in = stuff_q ? comb_q : '0;
  // Low-rate comb chain: delay lines shift and c3 is captured only on slot edges
  always_ff @(posedge cic_clk or negedge cic_rstn) begin
    if (!cic_rstn) begin
      x1_q   <= '0;
      x2_q   <= '0;
      c11_q  <= '0;
      c12_q  <= '0;
      c21_q  <= '0;
      c22_q  <= '0;
      comb_q <= '0;
    end else if (slot) begin
      x1_q   <= x;
      x2_q   <= x1_q;
      c11_q  <= c1;
      c12_q  <= c11_q;
      c21_q  <= c2;
      c22_q  <= c21_q;
      comb_q <= c3;
    end
  end
  // High-rate integrators fed with zero-stuffed comb output
  always_ff @(posedge cic_clk or negedge cic_rstn) begin
    if (!cic_rstn) begin
      stuff_q <= 1'b0;
      i1_q    <= '0;
      i2_q    <= '0;
      i3_q    <= '0;
    end else begin
      stuff_q <= slot;
      if (state_q == RUN) begin
        i1_q <= i1_q + int_in;
        i2_q <= i2_q + i1_q;
        i3_q <= i3_q + i2_q;
      end
    end
  end
  // Status: underflow pulse after a missed slot, valid latched three edges after first accept
  always_ff @(posedge cic_clk or negedge cic_rstn) begin
    if (!cic_rstn) begin
      uf_q    <= 1'b0;
      first_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      uf_q    <= miss;
      first_q <= {first_q[1:0], first};
      vld_q   <= vld_q || first_q[2];
    end
  end
  assign cic_dout       = i3_q;
  assign cic_dout_valid = vld_q;
  assign cic_underflow  = uf_q;
endmodule

// File: tb/tb_cic_interpolator.sv
// tb_cic_interpolator: directed self-checking bench for cic_interpolator.
module tb_cic_interpolator;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic signed [7:0] din = '0;
  logic valid = 1'b0;
  logic ready, dvalid, uf;
  logic signed [25:0] dout;
  int checks = 0;
  int failures = 0;

  cic_interpolator dut (
    .cic_clk(clk), .cic_rstn(rstn), .cic_din(din), .cic_din_valid(valid),
    .cic_din_ready(ready), .cic_dout(dout), .cic_dout_valid(dvalid), .cic_underflow(uf)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    valid = 1'b0;
    din = '0;
    rstn = 1'b0;
    cyc();
    cyc();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (ready !== 1'b1 || dout !== '0 || dvalid !== 1'b0 || uf !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL reset_idle: %0d bad cycles, required 0 (ready=%b dout=%0d valid=%b uf=%b)", bad, ready, dout, dvalid, uf);
    end
  endtask

  task automatic test_impulse();
    int exp_seq[4] = '{1, 3, 6, 10};
    longint sum;
    int ufc;
    do_reset();
    din = 8'sd1;
    valid = 1'b1;
    cyc();
    din = '0;
    cyc();
    cyc();
    checks++;
    if (dout !== '0 || dvalid !== 1'b0) begin
      failures++;
      $display("FAIL impulse_pre: dout=%0d valid=%b, required 0 and 0 after E2", dout, dvalid);
    end
    sum = 0;
    ufc = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      sum += longint'(dout);
      checks++;
      if ($signed(dout) !== exp_seq[i] || dvalid !== 1'b1) begin
        failures++;
        $display("FAIL impulse_e%0d: dout=%0d valid=%b, required %0d and 1", i + 3, dout, dvalid, exp_seq[i]);
      end
    end
    for (int i = 0; i < 300; i++) begin
      cyc();
      sum += longint'(dout);
      if (uf !== 1'b0) ufc++;
    end
    checks++;
    if (sum !== 64'sd262144) begin
      failures++;
      $display("FAIL impulse_sum: sum=%0d, required 262144", sum);
    end
    checks++;
    if (dout !== '0 || ufc !== 0) begin
      failures++;
      $display("FAIL impulse_tail: dout=%0d uf_cycles=%0d, required 0 and 0", dout, ufc);
    end
  endtask

  task automatic test_step(input logic signed [7:0] v, input int expv, input string nm);
    int ufc, bad;
    do_reset();
    din = v;
    valid = 1'b1;
    ufc = 0;
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      cyc();
      if (uf !== 1'b0) ufc++;
    end
    for (int i = 0; i < 64; i++) begin
      cyc();
      if (uf !== 1'b0) ufc++;
      if ($signed(dout) !== expv) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL %s_settle: dout=%0d with %0d bad cycles, required %0d", nm, dout, bad, expv);
    end
    checks++;
    if (ufc !== 0) begin
      failures++;
      $display("FAIL %s_underflow: %0d underflow cycles, required 0", nm, ufc);
    end
  endtask

  task automatic test_underflow();
    int n, mn, ufc;
    n = 0;
    while (ready !== 1'b1 && n < 64) begin
      cyc();
      n++;
    end
    checks++;
    if (ready !== 1'b1) begin
      failures++;
      $display("FAIL uf_wait_ready: ready=%b, required 1 within 64 cycles", ready);
    end
    valid = 1'b0;
    cyc();
    valid = 1'b1;
    checks++;
    if (uf !== 1'b1) begin
      failures++;
      $display("FAIL uf_pulse: uf=%b, required 1 after missed slot", uf);
    end
    cyc();
    checks++;
    if (uf !== 1'b0) begin
      failures++;
      $display("FAIL uf_pulse_len: uf=%b, required 0 one cycle later", uf);
    end
    mn = $signed(dout);
    ufc = 0;
    for (int i = 0; i < 250; i++) begin
      cyc();
      if ($signed(dout) < mn) mn = $signed(dout);
      if (uf !== 1'b0) ufc++;
    end
`ifdef CIC_INTERP_UNDERFLOW_HOLD_EN
    checks++;
    if (mn !== 1040384) begin
      failures++;
      $display("FAIL uf_hold: min dout=%0d, required 1040384", mn);
    end
`else
    checks++;
    if (mn >= 1040384) begin
      failures++;
      $display("FAIL uf_dip: min dout=%0d, required below 1040384", mn);
    end
`endif
    checks++;
    if ($signed(dout) !== 1040384 || ufc !== 0) begin
      failures++;
      $display("FAIL uf_recover: dout=%0d uf_cycles=%0d, required 1040384 and 0", dout, ufc);
    end
  endtask

  task automatic test_handshake();
    int rdy, acc, dbl;
    logic prev;
    do_reset();
    din = 8'sd5;
    valid = 1'b1;
    cyc();
    rdy = 0;
    acc = 0;
    dbl = 0;
    prev = 1'b0;
    for (int i = 0; i < 320; i++) begin
      if (ready === 1'b1) rdy++;
      if (ready === 1'b1 && valid === 1'b1) acc++;
      if (ready === 1'b1 && prev === 1'b1) dbl++;
      prev = ready;
      cyc();
    end
    checks++;
    if (rdy !== 10 || dbl !== 0) begin
      failures++;
      $display("FAIL hs_ready: ready cycles=%0d back-to-back=%0d, required 10 and 0", rdy, dbl);
    end
    checks++;
    if (acc !== 10) begin
      failures++;
      $display("FAIL hs_accepts: accepts=%0d, required 10", acc);
    end
  endtask

  task automatic test_midrun_reset();
    do_reset();
    din = 8'sd127;
    valid = 1'b1;
    repeat (100) cyc();
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (dout !== '0 || dvalid !== 1'b0 || uf !== 1'b0 || ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset: dout=%0d valid=%b uf=%b ready=%b, required 0 0 0 1", dout, dvalid, uf, ready);
    end
    cyc();
    rstn = 1'b1;
    cyc();
    cyc();
    cyc();
    checks++;
    if (dout !== '0 || dvalid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_e2: dout=%0d valid=%b, required 0 and 0", dout, dvalid);
    end
    cyc();
    checks++;
    if ($signed(dout) !== 127 || dvalid !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_e3: dout=%0d valid=%b, required 127 and 1", dout, dvalid);
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_step(8'sd127, 1040384, "step_pos");
    test_underflow();
    test_step(-8'sd128, -1048576, "step_neg");
    test_handshake();
    test_midrun_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
